wb_burst_ctrl: RTL
==================

Name: wb_burst_ctrl

Overview:
Write-back burst controller for the data cache. It accepts a dirty cache block and its block address, then issues one AXI4 INCR write burst: the AW phase, then BLOCK_WIDTH/AXI_DATA_WIDTH W beats, then the B response. Beats are serialised LSB-word first through the team's shift_reg beat buffer. It sits between the cache FSM and the AXI master port and reports busy, done and error to the cache.

Parameters:
AXI_DATA_WIDTH, 32, width of one W beat in bits.
BLOCK_WIDTH, 512, cache block width in bits. Must be a power-of-two multiple of AXI_DATA_WIDTH.
ADDR_WIDTH, 64, AXI address width.

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, synchronous, active-low
start_i  in  1  write-back request; accepted only in IDLE
addr_i  in  ADDR_WIDTH  block address
data_block_i  in  BLOCK_WIDTH  block to write
busy_o  out  1  high whenever state is not IDLE
done_o  out  1  one-cycle pulse on burst completion
error_o  out  1  sticky error flag for the last burst: BRESP was SLVERR or DECERR
aw_valid_o  out  1  AXI AW valid
aw_ready_i  in  1  AXI AW ready
aw_addr_o  out  ADDR_WIDTH  burst address
aw_len_o  out  8  BEATS-1
aw_size_o  out  3  log2(AXI_DATA_WIDTH/8)
aw_burst_o  out  2  fixed 2'b01 (INCR)
w_valid_o  out  1  AXI W valid
w_ready_i  in  1  AXI W ready
w_data_o  out  AXI_DATA_WIDTH  current beat
w_last_o  out  1  final beat marker
b_valid_i  in  1  AXI B valid
b_ready_o  out  1  AXI B ready
b_resp_i  in  2  AXI B response

Behaviour:
- One clock (clk_i). Reset is synchronous, active-low (rst_n_i).
- Reset (rst_n_i=0 sampled at a clock edge) forces:
  - state IDLE; beat counter 0; buffer cleared.
  - Outputs to 0: aw_valid_o, w_valid_o, b_ready_o, busy_o, done_o, error_o, aw_addr_o.
  - Reset mid-burst abandons the burst silently. No further AXI traffic follows.
- BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH. Elaboration fails if BEATS > 256 or BEATS is not a power of two.
- States:
  - IDLE: start_i=1 latches addr_i into aw_addr_o, with the low log2(BLOCK_WIDTH/8) bits forced to 0. It also loads data_block_i into the buffer and clears error_o. Next state ADDR.
  - ADDR: aw_valid_o=1. On aw_valid_o&aw_ready_i, go to DATA.
  - DATA:
    - w_valid_o=1; w_data_o = buffer LSB word.
    - Each w_valid_o&w_ready_i shifts the buffer by one word and increments the counter.
    - w_last_o = (counter == BEATS-1).
    - The handshake on the last beat moves to RESP.
  - RESP: b_ready_o=1. On b_valid_i, error_o <= b_resp_i[1], done_o pulses in the next cycle, and the state returns to IDLE.
- AW and W never overlap; W starts the cycle after the AW handshake.
- Valid signals hold until their handshake completes. aw_addr_o and w_data_o stay stable while valid is high and ready is low.
- aw_len_o, aw_size_o and aw_burst_o are constants.
- start_i while busy_o=1 is ignored; no queuing.
- done_o and busy_o=0 appear in the same cycle. start_i is accepted in that cycle.
- error_o holds until the next accepted start or reset.
- Minimum latency with all readys high:
  - start at cycle 0; AW handshake cycle 1; W beats cycles 2..BEATS+1.
  - B accepted at cycle BEATS+2 or later; done_o at cycle BEATS+3 or later.
- Backpressure (w_ready_i low) stalls the counter and buffer with no data loss.

Decomposition:
- Shared package holds:
  - AXI_BURST_INCR = 2'b01.
  - AXI_RESP_OKAY / EXOKAY / SLVERR / DECERR.
  - State enum wb_state_t {IDLE, ADDR, DATA, RESP}.
  - Function clog2-based beat_size(AXI_DATA_WIDTH).
- One sub-module: shift_reg as the beat buffer.
  - axi_free_i = IDLE & start_i (load).
  - write_en_i = W handshake; data_i = '0.
  - data_o drives w_data_o.

Test Plan:
1. Reset then idle: hold rst_n_i=0 for 2 cycles -> all outputs 0. Then start_i=0 for 10 cycles -> busy_o=0 and no valid asserted.
2. Full-speed burst: defaults; addr_i=0x1000_0047; block words W[i]=0xA000_0000+i; all readys high; b_resp_i=OKAY.
   - aw_addr_o=0x1000_0040, aw_len_o=15, aw_size_o=2.
   - 16 beats with data 0xA000_0000..0xA000_000F; w_last_o only on the 16th beat.
   - done_o pulses once at cycle 19; error_o=0.
3. Backpressure: w_ready_i toggles 1,0,0,1,... and aw_ready_i is delayed 5 cycles.
   - Beat order and values are unchanged.
   - w_data_o is stable during stalls.
   - The exact beat count is 16.
4. Error response: b_resp_i=2'b10 -> error_o=1 after done_o. Next start_i clears error_o the following cycle.
5. start_i pulsed during DATA with a different block -> ignored; the original 16 beats complete unchanged. start_i coincident with done_o -> accepted, and aw_valid_o rises the next cycle.
6. rst_n_i low at beat 7 -> next cycle all valids 0, IDLE. A new start then produces a clean 16-beat burst from beat 0.

Source files
------------

// File: rtl/wb_burst_ctrl_pkg.sv
// Shared definitions for the data-cache write-back burst controller.
package wb_burst_ctrl_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } wb_state_t;

    // AXI AxSIZE encoding for a beat of data_width bits.
    function automatic logic [2:0] beat_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/wb_burst_ctrl_shift_reg.sv
// Beat buffer: parallel-load a whole block, then shift out one word per
// write, LSB word first, refilling from the top with data_i.
module shift_reg #(
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned BLOCK_WIDTH = 512
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   axi_free_i,
    input  logic [BLOCK_WIDTH-1:0] block_i,
    input  logic                   write_en_i,
    input  logic [WORD_WIDTH-1:0]  data_i,
    output logic [WORD_WIDTH-1:0]  data_o
);

    logic [BLOCK_WIDTH-1:0] blk_q;
    logic [BLOCK_WIDTH-1:0] blk_d;

    // Load has priority over shift; otherwise hold.
    always_comb begin
        blk_d = blk_q;
        if (axi_free_i) begin
            blk_d = block_i;
        end else if (write_en_i) begin
            blk_d = blk_q >> WORD_WIDTH;
            blk_d[BLOCK_WIDTH-1 -: WORD_WIDTH] = data_i;
        end
    end

    // Buffer register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            blk_q <= '0;
        end else begin
            blk_q <= blk_d;
        end
    end

    assign data_o = blk_q[WORD_WIDTH-1:0];

endmodule

// File: rtl/wb_burst_ctrl.sv
// Write-back burst controller: takes one dirty block and issues a single
// AXI4 INCR write burst (AW, then all W beats, then B), reporting
// busy/done/error back to the cache FSM.
module wb_burst_ctrl #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned BLOCK_WIDTH    = 512,
    parameter int unsigned ADDR_WIDTH     = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      start_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [BLOCK_WIDTH-1:0]    data_block_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,
    output logic [ADDR_WIDTH-1:0]     aw_addr_o,
    output logic [7:0]                aw_len_o,
    output logic [2:0]                aw_size_o,
    output logic [1:0]                aw_burst_o,
    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] w_data_o,
    output logic                      w_last_o,
    input  logic                      b_valid_i,
    output logic                      b_ready_o,
    input  logic [1:0]                b_resp_i
);

    import wb_burst_ctrl_pkg::*;

    localparam int unsigned BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W = $clog2(BLOCK_WIDTH / 8);
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;

    // Burst length must fit AWLEN and be a power of two of whole beats.
    if ((BLOCK_WIDTH % AXI_DATA_WIDTH) != 0 || BEATS == 0 || BEATS > 256 ||
        (BEATS & (BEATS - 1)) != 0) begin : g_bad_cfg
        $error("wb_burst_ctrl: BLOCK_WIDTH/AXI_DATA_WIDTH must be a power of two <= 256");
    end

    wb_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;

    logic                   aw_valid;
    logic                   w_valid;
    logic                   b_ready;
    logic                   load;
    logic                   w_hs;

    // Next-state, datapath updates and handshake-side outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        err_d    = err_q;
        done_d   = 1'b0;
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        b_ready  = 1'b0;
        load     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    addr_d  = addr_i & ADDR_MASK;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                aw_valid = 1'b1;
                if (aw_ready_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                w_valid = 1'b1;
                if (w_ready_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                b_ready = 1'b1;
                if (b_valid_i) begin
                    err_d   = (b_resp_i == AXI_RESP_SLVERR) ||
                              (b_resp_i == AXI_RESP_DECERR);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign w_hs = w_valid & w_ready_i;

    shift_reg #(
        .WORD_WIDTH  (AXI_DATA_WIDTH),
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_beat_buf (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .axi_free_i (load),
        .block_i    (data_block_i),
        .write_en_i (w_hs),
        .data_i     ('0),
        .data_o     (w_data_o)
    );

    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign error_o    = err_q;
    assign aw_valid_o = aw_valid;
    assign aw_addr_o  = addr_q;
    assign aw_len_o   = 8'(BEATS - 1);
    assign aw_size_o  = beat_size(AXI_DATA_WIDTH);
    assign aw_burst_o = AXI_BURST_INCR;
    assign w_valid_o  = w_valid;
    assign w_last_o   = w_valid & (cnt_q == LAST_CNT);
    assign b_ready_o  = b_ready;

endmodule
